// File: rtl/shift_cmd_pipe.sv
// Flow-controlled shift command stage: command FIFO, LSL/LSR/ASR/ROT datapath, registered output.
// Optional macro SHIFT_CMD_PIPE_STATS_EN adds saturating done_cnt/stall_cnt statistics ports.
module shift_cmd_pipe #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_data,
   input  logic [4:0]               in_amt,
   input  logic [1:0]               in_op,
   input  logic                     in_dir,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_q,
   output logic                     out_carry,
   output logic                     out_zero,
   output logic [TAG_W-1:0]         out_tag,
   output logic [$clog2(DEPTH):0]   level
`ifdef SHIFT_CMD_PIPE_STATS_EN
   ,
   output logic [15:0]              done_cnt,
   output logic [15:0]              stall_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             dir;
      logic [1:0]       op;
      logic [4:0]       amt;
      logic [31:0]      data;
   } cmd_t;

   cmd_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             out_valid_q, out_valid_d;
   logic [31:0]      res_q, res_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic [TAG_W-1:0] tag_q, tag_d;

   logic push, pop;
   cmd_t head;
   cmd_t in_cmd;

   logic [31:0] sh_q;
   logic        sh_c;
   logic [32:0] lsl_w, lsr_w, asr_w;
   logic [31:0] rotl_w, rotr_w;
   logic [5:0]  inv_amt;

   assign in_ready = !rst && (level_q < FULL);
   assign push     = in_valid && in_ready;
   assign pop      = (level_q != '0) && (!out_valid_q || out_ready);
   assign head     = mem_q[rd_ptr_q];

   always_comb begin
      in_cmd      = '0;
      in_cmd.tag  = in_tag;
      in_cmd.dir  = in_dir;
      in_cmd.op   = in_op;
      in_cmd.amt  = in_amt;
      in_cmd.data = in_data;
   end

   // Extra guard bit catches the last bit shifted out; amt=0 leaves it clear.
   always_comb begin
      inv_amt = 6'd32 - {1'b0, head.amt};
      lsl_w   = {1'b0, head.data} << head.amt;
      lsr_w   = {head.data, 1'b0} >> head.amt;
      asr_w   = 33'($signed({head.data, 1'b0}) >>> head.amt);
      rotl_w  = (head.data << head.amt) | (head.data >> inv_amt);
      rotr_w  = (head.data >> head.amt) | (head.data << inv_amt);
      sh_q    = head.data;
      sh_c    = 1'b0;
      case (head.op)
         2'b00: begin
            sh_q = lsl_w[31:0];
            sh_c = lsl_w[32];
         end
         2'b01: begin
            sh_q = lsr_w[32:1];
            sh_c = lsr_w[0];
         end
         2'b10: begin
            sh_q = asr_w[32:1];
            sh_c = asr_w[0];
         end
         default: begin
            sh_q = head.dir ? rotr_w : rotl_w;
            sh_c = (head.amt != 5'd0) && (head.dir ? rotr_w[31] : rotl_w[0]);
         end
      endcase
   end

   always_comb begin
      wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d     = level_q;
      if (push && !pop) level_d = level_q + LVL_W'(1);
      else if (!push && pop) level_d = level_q - LVL_W'(1);
      out_valid_d = out_valid_q;
      res_d       = res_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      tag_d       = tag_q;
      if (pop) begin
         out_valid_d = 1'b1;
         res_d       = sh_q;
         carry_d     = sh_c;
         zero_d      = (sh_q == 32'd0);
         tag_d       = head.tag;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         tag_q       <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         tag_q       <= tag_d;
      end
   end

   // Storage needs no reset: entries are only read below the level count.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_cmd;
   end

   assign out_valid = out_valid_q;
   assign out_q     = res_q;
   assign out_carry = carry_q;
   assign out_zero  = zero_q;
   assign out_tag   = tag_q;
   assign level     = level_q;

`ifdef SHIFT_CMD_PIPE_STATS_EN
   logic [15:0] done_q, done_d;
   logic [15:0] stall_q, stall_d;

   always_comb begin
      done_d  = done_q;
      stall_d = stall_q;
      if (out_valid_q && out_ready && done_q != 16'hFFFF) done_d = done_q + 16'd1;
      if (in_valid && !in_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done_q  <= '0;
         stall_q <= '0;
      end else begin
         done_q  <= done_d;
         stall_q <= stall_d;
      end
   end

   assign done_cnt  = done_q;
   assign stall_cnt = stall_q;
`endif

endmodule
